// File: rtl/dmem_stall_unit_if.sv
// dmem_stall_unit_if: request/response bundle between the datapath and the data-memory stage.
interface dmem_stall_unit_if;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  MemSize;
   logic        MemUnsigned;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Stall;
   logic        MisalignFault;
   logic        ReqDone;
   modport master (
      output MemRead, MemWrite, MemSize, MemUnsigned, ALUResult, WriteData,
      input  ReadData, Stall, MisalignFault, ReqDone
   );
   modport slave (
      input  MemRead, MemWrite, MemSize, MemUnsigned, ALUResult, WriteData,
      output ReadData, Stall, MisalignFault, ReqDone
   );
endinterface

// File: rtl/dmem_stall_unit.sv
// dmem_stall_unit: wait-stated data memory with byte/half/word access, extension and alignment faults.
module dmem_stall_unit #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic clk,
   input logic reset,
   dmem_stall_unit_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(WAIT_CYCLES + 2);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [1:0]    size_q;
   logic          uns_q, wr_q;

   logic          req, illegal, accept, access, use_in;
   logic [AW+1:0] a_addr;
   logic [31:0]   a_wdata;
   logic [1:0]    a_size;
   logic          a_uns, a_wr;
   logic [AW-1:0] a_idx;
   logic [1:0]    a_off;
   logic [31:0]   rd_word, lane_data, wlane;
   logic [15:0]   half;
   logic [7:0]    byte_v;
   logic [3:0]    be;

   logic [31:0]   mem_q [DEPTH_WORDS];

   assign req     = bus.MemRead | bus.MemWrite;
   assign illegal = (bus.MemRead & bus.MemWrite) | (bus.MemSize == 2'b11) |
                    ((bus.MemSize == 2'b01) & bus.ALUResult[0]) |
                    ((bus.MemSize == 2'b10) & (|bus.ALUResult[1:0]));
   assign accept  = (state_q == S_IDLE) & req & ~illegal;

   // With zero wait states the access happens straight from the live inputs in IDLE.
   assign use_in  = state_q == S_IDLE;
   assign a_addr  = use_in ? bus.ALUResult[AW+1:0] : addr_q;
   assign a_wdata = use_in ? bus.WriteData : wdata_q;
   assign a_size  = use_in ? bus.MemSize : size_q;
   assign a_uns   = use_in ? bus.MemUnsigned : uns_q;
   assign a_wr    = use_in ? bus.MemWrite : wr_q;
   assign access  = (accept & (WAIT_CYCLES == 0)) | ((state_q == S_BUSY) & (cnt_q == CW'(1)));

   assign a_idx   = a_addr[AW+1:2];
   assign a_off   = a_addr[1:0];

   always_comb begin
      rd_word   = mem_q[a_idx];
      byte_v    = rd_word[{a_off, 3'b000} +: 8];
      half      = a_off[1] ? rd_word[31:16] : rd_word[15:0];
      lane_data = (a_size == 2'b00) ? {{24{~a_uns & byte_v[7]}}, byte_v} :
                  (a_size == 2'b01) ? {{16{~a_uns & half[15]}}, half} : rd_word;
      be        = (a_size == 2'b00) ? 4'b0001 << a_off :
                  (a_size == 2'b01) ? (a_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wlane     = (a_size == 2'b00) ? {4{a_wdata[7:0]}} :
                  (a_size == 2'b01) ? {2{a_wdata[15:0]}} : a_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && accept) begin
         addr_q  <= bus.ALUResult[AW+1:0];
         wdata_q <= bus.WriteData;
         size_q  <= bus.MemSize;
         uns_q   <= bus.MemUnsigned;
         wr_q    <= bus.MemWrite;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && access && a_wr)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem_q[a_idx][8*i +: 8] <= wlane[8*i +: 8];
   end

   always_comb begin
      state_d = (state_q == S_IDLE) ? (accept ? ((WAIT_CYCLES == 0) ? S_DONE : S_BUSY) : S_IDLE) :
                (state_q == S_BUSY) ? (access ? S_DONE : S_BUSY) : S_IDLE;
      cnt_d   = accept ? CW'(WAIT_CYCLES) :
                ((state_q == S_BUSY) && (cnt_q > CW'(1))) ? cnt_q - CW'(1) : cnt_q;
      rdata_d = (access && !a_wr) ? lane_data : rdata_q;
   end

   // Outputs are forced low while reset is held so the datapath never sees a stale stall.
   always_comb begin
      bus.Stall         = reset & (accept | (state_q == S_BUSY));
      bus.MisalignFault = reset & (state_q == S_IDLE) & req & illegal;
      bus.ReqDone       = reset & (state_q == S_DONE);
      bus.ReadData      = rdata_q;
   end
endmodule

// File: tb/tb_dmem_stall_unit.sv
// tb_dmem_stall_unit: table vectors, corner sequences and a byte-array reference model for dmem_stall_unit.
module tb_dmem_stall_unit;
   localparam int DEPTH  = 256;
   localparam int WAIT_A = 2;
   localparam int NBYTES = DEPTH * 4;

   logic clk = 1'b0;
   logic reset_a, reset_b;
   int   vectors = 0;
   int   miscompares = 0;

   dmem_stall_unit_if ifa ();
   dmem_stall_unit_if ifb ();

   dmem_stall_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) u_a (.clk(clk), .reset(reset_a), .bus(ifa));
   dmem_stall_unit #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0))      u_b (.clk(clk), .reset(reset_b), .bus(ifb));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   logic [7:0]  mem_m [NBYTES];
   logic [31:0] rd_m;

   typedef struct {
      bit          mr;
      bit          mw;
      logic [1:0]  sz;
      bit          uns;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          fault;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl [15];

   function automatic bit m_legal(bit mr, bit mw, logic [1:0] sz, logic [31:0] a);
      int n;
      if (mr && mw) return 1'b0;
      if (sz == 2'd3) return 1'b0;
      n = 1 << sz;
      return (a % n) == 0;
   endfunction

   function automatic logic [31:0] m_load(logic [1:0] sz, bit uns, logic [31:0] a);
      int     n    = 1 << sz;
      int     base = int'(a % NBYTES);
      longint v    = 0;
      for (int k = 0; k < n; k++) v = v + (longint'(mem_m[(base + k) % NBYTES]) << (8 * k));
      if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic m_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
      int n    = 1 << sz;
      int base = int'(a % NBYTES);
      for (int k = 0; k < n; k++) mem_m[(base + k) % NBYTES] = 8'((wd >> (8 * k)) & 32'hFF);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_a(bit mr, bit mw, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
      ifa.MemRead = mr; ifa.MemWrite = mw; ifa.MemSize = sz;
      ifa.MemUnsigned = uns; ifa.ALUResult = a; ifa.WriteData = wd;
   endtask

   task automatic drive_b(bit mr, bit mw, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
      ifb.MemRead = mr; ifb.MemWrite = mw; ifb.MemSize = sz;
      ifb.MemUnsigned = uns; ifb.ALUResult = a; ifb.WriteData = wd;
   endtask

   // One transaction on the WAIT_CYCLES=2 unit; the request stays up through DONE.
   task automatic xact(bit mr, bit mw, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd,
                       bit efault, logic [31:0] erd, string nm);
      int st;
      bit legal_req = (mr | mw) && !efault;
      @(posedge clk); #1;
      drive_a(mr, mw, sz, uns, a, wd);
      @(negedge clk);
      chk({nm, ".fault"}, 32'(ifa.MisalignFault), 32'(efault));
      if (!legal_req) begin
         chk({nm, ".stall"}, 32'(ifa.Stall), 32'd0);
         chk({nm, ".rd"}, ifa.ReadData, erd);
      end else begin
         st = 0;
         while (ifa.Stall === 1'b1 && st < 20) begin
            st++;
            @(negedge clk);
         end
         chk({nm, ".stall_cycles"}, st, WAIT_A + 1);
         chk({nm, ".done"}, 32'(ifa.ReqDone), 32'd1);
         chk({nm, ".rd"}, ifa.ReadData, erd);
      end
      @(posedge clk); #1;
      drive_a(0, 0, 2'd0, 0, 32'h0, 32'h0);
      if (legal_req) begin
         @(negedge clk);
         chk({nm, ".done_clear"}, {30'd0, ifa.ReqDone, ifa.Stall}, 32'd0);
      end
      if (legal_req && mw) m_store(sz, a, wd);
      if (legal_req && !mw) rd_m = m_load(sz, uns, a);
   endtask

   // Zero-wait unit: request held for two cycles must complete exactly once.
   task automatic bhold(bit mr, bit mw, logic [31:0] a, logic [31:0] wd, logic [31:0] erd, string nm);
      @(posedge clk); #1;
      drive_b(mr, mw, 2'd2, 0, a, wd);
      @(negedge clk);
      chk({nm, ".c1_stall"}, 32'(ifb.Stall), 32'd1);
      chk({nm, ".c1_done"}, 32'(ifb.ReqDone), 32'd0);
      @(negedge clk);
      chk({nm, ".c2_stall"}, 32'(ifb.Stall), 32'd0);
      chk({nm, ".c2_done"}, 32'(ifb.ReqDone), 32'd1);
      chk({nm, ".c2_rd"}, ifb.ReadData, erd);
      @(posedge clk); #1;
      drive_b(0, 0, 2'd0, 0, 32'h0, 32'h0);
      @(negedge clk);
      chk({nm, ".c3_done"}, 32'(ifb.ReqDone), 32'd0);
      chk({nm, ".c3_stall"}, 32'(ifb.Stall), 32'd0);
      chk({nm, ".c3_rd"}, ifb.ReadData, erd);
   endtask

   initial begin
      bit          mr, mw, uns, ef;
      logic [1:0]  sz;
      logic [31:0] a, wd, er;
      int          op;

      tbl[0]  = '{0, 1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 0, 32'h00000000};
      tbl[1]  = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF};
      tbl[2]  = '{0, 1, 2'd0, 0, 32'h11,  32'h0000005A, 0, 32'hDEADBEEF};
      tbl[3]  = '{1, 0, 2'd0, 0, 32'h11,  32'h0,        0, 32'h0000005A};
      tbl[4]  = '{1, 0, 2'd1, 0, 32'h12,  32'h0,        0, 32'hFFFFDEAD};
      tbl[5]  = '{1, 0, 2'd1, 1, 32'h12,  32'h0,        0, 32'h0000DEAD};
      tbl[6]  = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'hDEAD5AEF};
      tbl[7]  = '{1, 0, 2'd0, 1, 32'h10,  32'h0,        0, 32'h000000EF};
      tbl[8]  = '{1, 0, 2'd0, 0, 32'h10,  32'h0,        0, 32'hFFFFFFEF};
      tbl[9]  = '{1, 0, 2'd1, 0, 32'h13,  32'h0,        1, 32'hFFFFFFEF};
      tbl[10] = '{1, 0, 2'd2, 0, 32'h02,  32'h0,        1, 32'hFFFFFFEF};
      tbl[11] = '{1, 1, 2'd2, 0, 32'h20,  32'h11223344, 1, 32'hFFFFFFEF};
      tbl[12] = '{1, 0, 2'd2, 1, 32'h10,  32'h0,        0, 32'hDEAD5AEF};
      tbl[13] = '{0, 1, 2'd2, 0, 32'h400, 32'hCAFEF00D, 0, 32'hDEAD5AEF};
      tbl[14] = '{1, 0, 2'd2, 0, 32'h000, 32'h0,        0, 32'hCAFEF00D};

      drive_a(0, 0, 2'd0, 0, 32'h0, 32'h0);
      drive_b(0, 0, 2'd0, 0, 32'h0, 32'h0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_a = 1'b1;
      reset_b = 1'b1;
      @(negedge clk);
      chk("reset_a.rd", ifa.ReadData, 32'h0);
      chk("reset_a.flags", {29'd0, ifa.Stall, ifa.ReqDone, ifa.MisalignFault}, 32'h0);
      chk("reset_b.rd", ifb.ReadData, 32'h0);
      chk("reset_b.flags", {29'd0, ifb.Stall, ifb.ReqDone, ifb.MisalignFault}, 32'h0);
      rd_m = 32'h0;

      for (int i = 0; i < DEPTH; i++) xact(0, 1, 2'd2, 0, 32'(i * 4), 32'h0, 0, 32'h0, "init");
      for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;

      for (int i = 0; i < 15; i++)
         xact(tbl[i].mr, tbl[i].mw, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
              tbl[i].fault, tbl[i].rd, $sformatf("tbl%0d", i));

      // Reset during the second BUSY cycle must abort the pending store.
      xact(0, 1, 2'd2, 0, 32'h20, 32'h11111111, 0, rd_m, "abort_pre");
      @(posedge clk); #1;
      drive_a(0, 1, 2'd2, 0, 32'h20, 32'h12345678);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort.busy1_stall", 32'(ifa.Stall), 32'd1);
      @(posedge clk); #1;
      reset_a = 1'b0;
      drive_a(0, 0, 2'd0, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
      reset_a = 1'b1;
      @(negedge clk);
      chk("abort.flags", {29'd0, ifa.Stall, ifa.ReqDone, ifa.MisalignFault}, 32'h0);
      chk("abort.rd", ifa.ReadData, 32'h0);
      rd_m = 32'h0;
      xact(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h11111111, "abort_load");

      for (int i = 0; i < 200; i++) begin
         op  = int'($urandom_range(0, 3));
         mr  = op[0];
         mw  = op[1];
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a   = $urandom;
         wd  = $urandom;
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         ef  = (mr | mw) && !m_legal(mr, mw, sz, a);
         er  = ((mr && !mw) && !ef) ? m_load(sz, uns, a) : rd_m;
         xact(mr, mw, sz, uns, a, wd, ef, er, $sformatf("rnd%0d", i));
      end

      bhold(0, 1, 32'h30, 32'hA5A5A5A5, 32'h0, "w0_store");
      bhold(1, 0, 32'h30, 32'h0, 32'hA5A5A5A5, "w0_load");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
